// File: rtl/scope_pkg.sv
// Shared types and constant helpers for the N-channel triggered capture engine.
package scope_pkg;

    typedef enum logic [1:0] {
        MODE_FREE   = 2'b00,
        MODE_RISE   = 2'b01,
        MODE_FALL   = 2'b10,
        MODE_SINGLE = 2'b11
    } trig_mode_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRE       = 2'b01,
        WAIT_TRIG = 2'b10,
        POST      = 2'b11
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scope_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
module scope_frame_ram #(
    parameter int ADDR_W = 11,
    parameter int WIDTH  = 28
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_q
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // No reset on the read register so the store maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end

endmodule

// File: rtl/scope_capture_nch.sv
// Triggered N-channel capture: decimate, edge-trigger, store a pre/post frame
// into the back bank and serve the display bank by screen X coordinate.
module scope_capture_nch
    import scope_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 14,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = clog2(DEPTH),
    parameter int X_W      = 11,
    parameter int DECIM_W  = 8,
    parameter int CH_W     = max_int(1, clog2(CHANNELS))
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sample_en,
    input  logic [CHANNELS*DATA_W-1:0] data_in,
    input  logic [1:0]                 trig_mode,
    input  logic [CH_W-1:0]            trig_src,
    input  logic [DATA_W-1:0]          trig_level,
    input  logic [ADDR_W-1:0]          pretrig,
    input  logic [DECIM_W-1:0]         decim,
    input  logic                       arm,
    input  logic [X_W-1:0]             rd_x,
    input  logic [CH_W-1:0]            rd_ch,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       frame_valid,
    output logic                       triggered,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [X_W:0]      DEPTH_X   = (X_W + 1)'(DEPTH);

    state_t                 state, state_nxt;
    trig_mode_t             mode_l;
    logic [CH_W-1:0]        src_l;
    logic [DATA_W-1:0]      level_l, prev, cur;
    logic [DECIM_W-1:0]     decim_l, decim_cnt;
    logic [ADDR_W-1:0]      pretrig_l, pre_cnt, post_cnt, wr_ptr, trig_ptr;
    logic [ADDR_W-1:0]      start_addr [2];
    logic                   prev_valid, disp_bank, back_bank;
    logic                   tick, complete, accept, hit, fire, enter_pre;
    logic                   rd_ok_q;
    logic [CH_W-1:0]        rd_ch_q;
    logic [ADDR_W:0]        rd_addr;
    logic [CHANNELS*DATA_W-1:0] ram_q;

    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign back_bank = ~disp_bank;
    assign tick      = busy && sample_en && (decim_cnt == decim_l);
    assign complete  = (state == POST) && (post_cnt == '0);
    // The completion cycle only swaps banks; a strobe landing there is dropped.
    assign accept    = tick && !complete;
    assign triggered = fire;

    always_comb begin
        cur = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (src_l == CH_W'(k)) cur = data_in[k*DATA_W +: DATA_W];
    end

    always_comb begin
        hit = 1'b0;
        case (mode_l)
            MODE_FREE: hit = 1'b1;
            MODE_FALL: hit = prev_valid && (prev >= level_l) && (cur < level_l);
            default:   hit = prev_valid && (prev < level_l) && (cur >= level_l);
        endcase
    end

    always_comb begin
        state_nxt = state;
        enter_pre = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (trig_mode != MODE_SINGLE || arm) begin
                    state_nxt = PRE;
                    enter_pre = 1'b1;
                end
            end
            PRE: begin
                if (pre_cnt == pretrig_l) state_nxt = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (accept && hit) begin
                    fire      = 1'b1;
                    state_nxt = POST;
                end
            end
            POST: begin
                if (complete) begin
                    if (mode_l == MODE_SINGLE) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = PRE;
                        enter_pre = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mode_l        <= MODE_FREE;
            src_l         <= '0;
            level_l       <= '0;
            decim_l       <= '0;
            pretrig_l     <= '0;
            decim_cnt     <= '0;
            pre_cnt       <= '0;
            post_cnt      <= '0;
            wr_ptr        <= '0;
            trig_ptr      <= '0;
            prev          <= '0;
            prev_valid    <= 1'b0;
            disp_bank     <= 1'b0;
            start_addr[0] <= '0;
            start_addr[1] <= '0;
            frame_valid   <= 1'b0;
        end else begin
            state <= state_nxt;
            // A stale count above a newly latched ratio would never match, so clear it here.
            if (enter_pre) begin
                mode_l    <= trig_mode_t'(trig_mode);
                src_l     <= trig_src;
                level_l   <= trig_level;
                decim_l   <= decim;
                pretrig_l <= pretrig;
                decim_cnt <= '0;
                pre_cnt   <= '0;
            end else if (busy && sample_en) begin
                decim_cnt <= tick ? '0 : decim_cnt + 1'b1;
            end
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (state == PRE && accept) pre_cnt <= pre_cnt + 1'b1;
            if (state == PRE && state_nxt == WAIT_TRIG) prev_valid <= 1'b0;
            if (state == WAIT_TRIG && accept) begin
                prev       <= cur;
                prev_valid <= 1'b1;
            end
            if (fire) begin
                trig_ptr <= wr_ptr;
                post_cnt <= LAST_ADDR - pretrig_l;
            end else if (state == POST && accept) begin
                post_cnt <= post_cnt - 1'b1;
            end
            if (complete) begin
                disp_bank             <= back_bank;
                start_addr[back_bank] <= trig_ptr - pretrig_l;
                frame_valid           <= 1'b1;
            end
        end
    end

    // Qualifiers travel alongside the registered RAM read so rd_data stays aligned.
    assign rd_addr = {disp_bank, start_addr[disp_bank] + rd_x[ADDR_W-1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ok_q <= 1'b0;
            rd_ch_q <= '0;
        end else begin
            rd_ok_q <= frame_valid && ({1'b0, rd_x} < DEPTH_X);
            rd_ch_q <= rd_ch;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (rd_ok_q && rd_ch_q == CH_W'(k)) rd_data = ram_q[k*DATA_W +: DATA_W];
    end

    scope_frame_ram #(
        .ADDR_W (ADDR_W + 1),
        .WIDTH  (CHANNELS * DATA_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (accept),
        .wr_addr ({back_bank, wr_ptr}),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_q    (ram_q)
    );

endmodule
